// File: rtl/rgb_show_ctrl.sv
// Multi-mode RGB LED light-show controller: off, siren, blink, chase, breathe.
// All animation timing comes from an internal prescaler; outputs are registered.
module rgb_show_ctrl #(
  parameter int N_CH = 2,
  parameter int OP_W = 11,
  parameter int TICK_DIV = 50_000_000,
  parameter int PWM_W = 8,
  parameter logic [OP_W-1:0] OP_SIREN = 11'b00000010000,
  parameter logic [OP_W-1:0] OP_BLINK = 11'b00000100000,
  parameter logic [OP_W-1:0] OP_CHASE = 11'b00001000000,
  parameter logic [OP_W-1:0] OP_BREATHE = 11'b00010000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op_code,
  output logic [3*N_CH-1:0] rgb,
  output logic [2:0]        mode
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam int IX_W = $clog2(N_CH);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
  localparam logic [IX_W-1:0] IX_MAX = IX_W'(N_CH - 1);
  localparam logic [PWM_W-1:0] DUTY_TOP = '1;
  localparam logic [PWM_W-1:0] DUTY_ONE = PWM_W'(1);

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_SIREN   = 3'd1,
    M_BLINK   = 3'd2,
    M_CHASE   = 3'd3,
    M_BREATHE = 3'd4
  } mode_e;

  mode_e              dec;
  mode_e              mode_q;
  logic [PS_W-1:0]    ps_q, ps_d;
  logic               phase_q, phase_d;
  logic [IX_W-1:0]    idx_q, idx_d;
  logic [PWM_W-1:0]   duty_q, duty_d;
  logic               down_q, down_d;
  logic [PWM_W-1:0]   pwm_q, pwm_d;
  logic [3*N_CH-1:0]  rgb_q, rgb_d;
  logic               tick;
  logic               chg;

  always_comb begin
    dec = M_OFF;
    unique case (1'b1)
      (op_code == OP_SIREN):   dec = M_SIREN;
      (op_code == OP_BLINK):   dec = M_BLINK;
      (op_code == OP_CHASE):   dec = M_CHASE;
      (op_code == OP_BREATHE): dec = M_BREATHE;
      default:                 dec = M_OFF;
    endcase
  end

  assign tick = (mode_q != M_OFF) && (ps_q == PS_MAX);
  assign chg  = (dec != mode_q);

  always_comb begin
    ps_d    = ps_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    duty_d  = duty_q;
    down_d  = down_q;
    pwm_d   = pwm_q;
    if (chg) begin
      ps_d    = '0;
      phase_d = 1'b0;
      idx_d   = '0;
      duty_d  = '0;
      down_d  = 1'b0;
      pwm_d   = '0;
    end else begin
      pwm_d = pwm_q + 1'b1;
      if (mode_q == M_OFF || tick) ps_d = '0;
      else ps_d = ps_q + 1'b1;
      if (tick) begin
        phase_d = ~phase_q;
        idx_d   = (idx_q == IX_MAX) ? '0 : idx_q + 1'b1;
        // Direction flips on the tick that lands on an endpoint.
        if (!down_q) begin
          duty_d = duty_q + 1'b1;
          if (duty_q == DUTY_TOP - DUTY_ONE) down_d = 1'b1;
        end else begin
          duty_d = duty_q - 1'b1;
          if (duty_q == DUTY_ONE) down_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode_q)
        M_SIREN:
          rgb_d[3*i +: 3] = (((i % 2) == 0) ^ phase_q) ? 3'b100 : 3'b001;
        M_BLINK:
          rgb_d[3*i +: 3] = phase_q ? 3'b000 : 3'b111;
        M_CHASE:
          rgb_d[3*i +: 3] = (idx_q == IX_W'(i)) ? 3'b010 : 3'b000;
        M_BREATHE:
          rgb_d[3*i +: 3] = {1'b0, (pwm_q < duty_q), 1'b0};
        default:
          rgb_d[3*i +: 3] = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= M_OFF;
      ps_q    <= '0;
      phase_q <= 1'b0;
      idx_q   <= '0;
      duty_q  <= '0;
      down_q  <= 1'b0;
      pwm_q   <= '0;
      rgb_q   <= '0;
    end else begin
      mode_q  <= dec;
      ps_q    <= ps_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      duty_q  <= duty_d;
      down_q  <= down_d;
      pwm_q   <= pwm_d;
      rgb_q   <= rgb_d;
    end
  end

  assign rgb  = rgb_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_rgb_show_ctrl.sv
// Scoreboard bench for rgb_show_ctrl: an elapsed-time reference model queues
// the expected rgb/mode per edge and a negedge monitor checks the DUT.
module tb_rgb_show_ctrl;

  localparam int N  = 3;
  localparam int TD = 4;
  localparam int PW = 3;
  localparam logic [10:0] OP_SIREN   = 11'b00000010000;
  localparam logic [10:0] OP_BLINK   = 11'b00000100000;
  localparam logic [10:0] OP_CHASE   = 11'b00001000000;
  localparam logic [10:0] OP_BREATHE = 11'b00010000000;

  typedef struct {
    logic [3*N-1:0] rgb;
    logic [2:0]     mode;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [10:0]    op_code;
  logic [3*N-1:0] rgb;
  logic [2:0]     mode;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  rgb_show_ctrl #(
    .N_CH(N), .OP_W(11), .TICK_DIV(TD), .PWM_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .rgb(rgb), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic int decode(input logic [10:0] op);
    if (op == OP_SIREN) return 1;
    if (op == OP_BLINK) return 2;
    if (op == OP_CHASE) return 3;
    if (op == OP_BREATHE) return 4;
    return 0;
  endfunction

  // Pattern for a mode that has been active for e cycles since its load edge.
  function automatic logic [3*N-1:0] pattern(input int m, input int e);
    logic [3*N-1:0] p;
    int n, per, k, duty, pwm;
    p    = '0;
    n    = e / TD;
    per  = 2 * ((1 << PW) - 1);
    k    = n % per;
    duty = (k <= (1 << PW) - 1) ? k : per - k;
    pwm  = e % (1 << PW);
    for (int i = 0; i < N; i++) begin
      case (m)
        1: p[3*i +: 3] = (((i % 2) == 0) == ((n % 2) == 0)) ? 3'b100 : 3'b001;
        2: p[3*i +: 3] = ((n % 2) == 0) ? 3'b111 : 3'b000;
        3: p[3*i +: 3] = (i == n % N) ? 3'b010 : 3'b000;
        4: p[3*i +: 3] = {1'b0, (pwm < duty), 1'b0};
        default: p[3*i +: 3] = 3'b000;
      endcase
    end
    return p;
  endfunction

  initial begin : model
    int m, e, d;
    logic [3*N-1:0] pat;
    exp_t x;
    m = 0; e = 0; pat = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m = 0; e = 0; pat = '0;
        x.rgb = '0;
      end else begin
        x.rgb = pat;
        d = decode(op_code);
        if (d != m) begin
          m = d; e = 0;
        end else begin
          e++;
        end
        pat = pattern(m, e);
      end
      x.mode = m[2:0];
      x.cyc  = cyc;
      q.push_back(x);
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        n_cmp++;
        if (rgb !== x.rgb) begin
          n_bad++;
          $display("FAIL rgb cyc=%0d got=%b want=%b", x.cyc, rgb, x.rgb);
        end
        n_cmp++;
        if (mode !== x.mode) begin
          n_bad++;
          $display("FAIL mode cyc=%0d got=%0d want=%0d", x.cyc, mode, x.mode);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [10:0] op, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r;
      op_code = op;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [10:0] ops[7];
    logic [10:0] op;
    int len;
    rst = 1'b1;
    op_code = OP_SIREN;
    drive(1'b1, OP_SIREN, 1);
    drive(1'b0, OP_SIREN, 20);
    drive(1'b0, OP_BLINK, 12);
    drive(1'b0, 11'h7FF, 1);
    drive(1'b0, OP_BLINK, 12);
    drive(1'b0, OP_CHASE, 30);
    drive(1'b0, OP_BREATHE, 22);
    drive(1'b1, OP_BREATHE, 1);
    drive(1'b0, OP_BREATHE, 70);
    ops[0] = 11'd0;
    ops[1] = OP_SIREN;
    ops[2] = OP_BLINK;
    ops[3] = OP_CHASE;
    ops[4] = OP_BREATHE;
    ops[5] = 11'h7FF;
    for (int s = 0; s < 40; s++) begin
      ops[6] = 11'($urandom);
      op  = ops[$urandom_range(0, 6)];
      len = $urandom_range(1, 15);
      if ($urandom_range(0, 9) == 0) drive(1'b1, op, 1);
      drive(1'b0, op, len);
    end
    drive(1'b0, OP_BREATHE, 3);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_show_ctrl.md
# rgb_show_ctrl

Parametrised multi-mode RGB LED light-show controller, successor to the single-mode siren show. Decodes the terminal's op_code every clock into one of five display modes (off, siren, blink, chase, breathe) and drives N_CH RGB LEDs with registered outputs. Timing is derived from an internal prescaler, so no external slow clock is needed. It sits between the op_code decoder and the board's RGB LED pins.

## Interface
- N_CH, 2: number of RGB LEDs driven (≥2)
- OP_W, 11: op_code width
- TICK_DIV, 50_000_000: clk cycles per animation tick (≥2)
- PWM_W, 8: breathe-mode PWM resolution in bits
- OP_SIREN, 11'b00000010000: op_code selecting SIREN
- OP_BLINK, 11'b00000100000: op_code selecting BLINK
- OP_CHASE, 11'b00001000000: op_code selecting CHASE
- OP_BREATHE, 11'b00010000000: op_code selecting BREATHE

- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- op_code  in  OP_W  command word, level-sensitive, sampled every cycle
- rgb  out  3*N_CH  LED drive; channel i = rgb[3i+2:3i], bit order {R,G,B}, 1 = on
- mode  out  3  current mode: 0 OFF, 1 SIREN, 2 BLINK, 3 CHASE, 4 BREATHE

## Operation
- Decode: op_code exactly equal to an OP_* parameter selects that mode; any other value selects OFF. Decoded mode is registered into `mode` every cycle.
- Mode change (registered mode differs from newly decoded mode): prescaler, step counter, chase index, duty and direction all clear to 0 in the same cycle the new mode is loaded.
- Prescaler: counts 0..TICK_DIV-1, wraps; `tick` is asserted for one cycle when count = TICK_DIV-1. Runs in all modes except OFF (held at 0).
- Phase bit: toggles on each tick (SIREN, BLINK).
- OFF: rgb = all 0.
- SIREN: phase 0 → even channels 3'b100 (red), odd channels 3'b001 (blue); phase 1 → swapped.
- BLINK: phase 0 → all channels 3'b111; phase 1 → all 3'b000.
- CHASE: index 0..N_CH-1, increments per tick, wraps N_CH-1 → 0; channel == index shows 3'b010, all others 3'b000.
- BREATHE: free-running PWM_W-bit counter pwm_cnt (cleared on mode change). Duty (PWM_W bits) steps by 1 per tick in a triangle: up from 0 to 2^PWM_W-1, then down to 0, then up; each endpoint is held for exactly one tick (direction flips on the tick that reaches it). All channels show {1'b0, pwm_cnt < duty, 1'b0}; duty 0 → fully off.
- Arithmetic: all counters unsigned, wrap explicitly at their limit; no counter ever exceeds its stated range.

## Timing
- Reset (rst high at a clk edge): mode = 0, rgb = 0, all counters, phase, index, duty = 0, direction = up. Reset mid-animation aborts immediately; first post-reset output follows decode as below.
- Latency: op_code change sampled at edge k → `mode` updated at edge k → rgb shows step-0 pattern of new mode after edge k+1 (one registered output stage).
- First tick after mode entry occurs TICK_DIV cycles after the mode load edge; pattern step 1 visible one cycle later.
- op_code glitch of a single cycle to another value causes a mode change and full counter restart on return (no filtering).
- Same op_code held: no restart; animation runs indefinitely.
- rst and op_code change in the same cycle: reset wins; the new op_code is decoded on the next edge.

## Test plan
- Reset: assert rst 2 cycles with op_code = OP_SIREN → mode = 0, rgb = 0 during reset; after release mode = 1 at next edge, rgb = 6'b001_100 one edge later.
- SIREN (TICK_DIV=4, N_CH=2): hold OP_SIREN → rgb alternates 6'b001_100 / 6'b100_001 every 4 cycles.
- CHASE (TICK_DIV=4, N_CH=3): hold OP_CHASE → rgb sequence 000_000_010, 000_010_000, 010_000_000, then wraps to 000_000_010, each for 4 cycles.
- BREATHE (TICK_DIV=2, PWM_W=3): duty sequence 0,1,…,7,6,…,0,1; at duty d green high for exactly d of each 8 cycles; duty 0 → rgb = 0.
- Mode switch/invalid op: BLINK running, op_code = 11'h7FF for 1 cycle then OP_BLINK → mode 0 then 2, rgb 0 then 111_111 restarting full phase-0 period.
- Mid-animation reset: BREATHE at duty 5, pulse rst → duty, pwm_cnt, rgb = 0; duty restarts at 0 counting up.
